// File: rtl/jtag_uart_mc_pkg.sv
// Shared definitions for the multi-channel JTAG UART: opcodes, STATUS field
// positions and the channel-index width helper.
package jtag_uart_mc_pkg;

    typedef enum logic [1:0] {
        OP_TX     = 2'd0,
        OP_RX     = 2'd1,
        OP_STATUS = 2'd2,
        OP_BYPASS = 2'd3
    } opcode_e;

    localparam int ST_TXMT = 0;
    localparam int ST_TXFL = 1;
    localparam int ST_RXMT = 2;
    localparam int ST_RXFL = 3;
    localparam int ST_OVF  = 4;
    localparam int ST_W    = 5;

    function automatic int chw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/jtag_uart_mc_fifo.sv
// Synchronous FIFO with registered empty/full flags and a combinational head word.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && !empty_q;
        do_push  = push_i && (!full_q || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
        // Flags follow the occupancy that this edge leaves behind
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (nreset_i && do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/jtag_uart_mc.sv
// Multi-channel JTAG UART: per-channel TX/RX FIFOs bridged to a JTAG data
// register selected by the instruction register.
module jtag_uart_mc
    import jtag_uart_mc_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 64,
    parameter int  NCH    = 2,
    localparam int CHW    = chw(NCH)
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic [NCH-1:0]        wr_i,
    input  logic [NCH*DATA_W-1:0] data_i,
    input  logic [NCH-1:0]        rd_i,
    output logic [NCH*DATA_W-1:0] data_o,
    output logic [NCH-1:0]        txmt_o,
    output logic [NCH-1:0]        txfl_o,
    output logic [NCH-1:0]        rxmt_o,
    output logic [NCH-1:0]        rxfl_o,
    input  logic [2+CHW-1:0]      ir_i,
    input  logic                  uir_i,
    input  logic                  cdr_i,
    input  logic                  sdr_i,
    input  logic                  udr_i,
    input  logic                  tdi_i,
    output logic                  tdo_o
);

    logic [NCH-1:0]        tx_empty, tx_full, rx_empty, rx_full;
    logic [NCH-1:0]        tx_pop, rx_push;
    logic [DATA_W-1:0]     tx_head [NCH];
    logic [DATA_W-1:0]     rx_head [NCH];

    logic [2+CHW-1:0]      ir_q, ir_d;
    logic [DATA_W:0]       sr_q, sr_d;
    logic                  byp_q, byp_d;
    logic [NCH-1:0]        ovf_q, ovf_d;
    logic [NCH*DATA_W-1:0] data_q, data_d;
    logic [ST_W-1:0]       status;
    opcode_e               op;
    logic [CHW-1:0]        sel;

    assign op  = opcode_e'(ir_q[1:0]);
    assign sel = ir_q[2 +: CHW];

    always_comb begin
        ir_d    = ir_q;
        sr_d    = sr_q;
        byp_d   = byp_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        tx_pop  = '0;
        rx_push = '0;

        status          = '0;
        status[ST_TXMT] = tx_empty[sel];
        status[ST_TXFL] = tx_full[sel];
        status[ST_RXMT] = rx_empty[sel];
        status[ST_RXFL] = rx_full[sel];
        status[ST_OVF]  = ovf_q[sel];

        // Out-of-range channels collapse to BYPASS so sel always names a real FIFO
        if (uir_i) begin
            if (int'(ir_i[2 +: CHW]) >= NCH) begin
                ir_d = {{CHW{1'b0}}, OP_BYPASS};
            end else begin
                ir_d = ir_i;
            end
        end

        if (cdr_i) begin
            case (op)
                OP_TX: begin
                    if (!tx_empty[sel]) begin
                        sr_d        = {tx_head[sel], 1'b1};
                        tx_pop[sel] = 1'b1;
                    end else begin
                        sr_d = '0;
                    end
                end
                OP_STATUS: begin
                    sr_d           = '0;
                    sr_d[ST_W-1:0] = status;
                    ovf_d[sel]     = 1'b0;
                end
                default: ;
            endcase
        end else if (sdr_i) begin
            if (op == OP_BYPASS) begin
                byp_d = tdi_i;
            end else begin
                sr_d = {tdi_i, sr_q[DATA_W:1]};
            end
        end

        // Evaluated after the STATUS clear so a same-cycle overflow keeps ovf set
        if (udr_i && op == OP_RX) begin
            if (!rx_full[sel]) begin
                rx_push[sel] = 1'b1;
            end else begin
                ovf_d[sel] = 1'b1;
            end
        end

        for (int c = 0; c < NCH; c++) begin
            if (rd_i[c] && !rx_empty[c]) begin
                data_d[c*DATA_W +: DATA_W] = rx_head[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            ir_q   <= {{CHW{1'b0}}, OP_BYPASS};
            sr_q   <= '0;
            byp_q  <= 1'b0;
            ovf_q  <= '0;
            data_q <= '0;
        end else begin
            ir_q   <= ir_d;
            sr_q   <= sr_d;
            byp_q  <= byp_d;
            ovf_q  <= ovf_d;
            data_q <= data_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
            .clk_i    (clk_i),
            .nreset_i (nreset_i),
            .push_i   (wr_i[c]),
            .pop_i    (tx_pop[c]),
            .data_i   (data_i[c*DATA_W +: DATA_W]),
            .head_o   (tx_head[c]),
            .empty_o  (tx_empty[c]),
            .full_o   (tx_full[c])
        );

        sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
            .clk_i    (clk_i),
            .nreset_i (nreset_i),
            .push_i   (rx_push[c]),
            .pop_i    (rd_i[c]),
            .data_i   (sr_q[DATA_W:1]),
            .head_o   (rx_head[c]),
            .empty_o  (rx_empty[c]),
            .full_o   (rx_full[c])
        );
    end

    assign data_o = data_q;
    assign txmt_o = tx_empty;
    assign txfl_o = tx_full;
    assign rxmt_o = rx_empty;
    assign rxfl_o = rx_full;
    assign tdo_o  = (op == OP_BYPASS) ? byp_q : sr_q[0];

endmodule

// File: tb/tb_jtag_uart_mc.sv
// Directed bench for jtag_uart_mc: a TX vector table plus hand-written
// sequences for FIFO full/overflow, bypass and mid-shift reset.
module tb_jtag_uart_mc;
    import jtag_uart_mc_pkg::*;

    localparam int DW  = 8;
    localparam int DEP = 64;
    localparam int NCH = 2;
    localparam int CHW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                nreset = 1'b0;
    logic [NCH-1:0]      wr = '0, rd = '0;
    logic [NCH*DW-1:0]   din = '0;
    logic [NCH*DW-1:0]   dout;
    logic [NCH-1:0]      txmt, txfl, rxmt, rxfl;
    logic [2+CHW-1:0]    ir = '0;
    logic                uir = 1'b0, cdr = 1'b0, sdr = 1'b0, udr = 1'b0, tdi = 1'b0;
    logic                tdo;

    logic [2:0]          wr3 = '0, rd3 = '0;
    logic [3*DW-1:0]     din3 = '0;
    logic [3*DW-1:0]     dout3;
    logic [2:0]          txmt3, txfl3, rxmt3, rxfl3;
    logic [3:0]          ir3 = '0;
    logic                uir3 = 1'b0, cdr3 = 1'b0, sdr3 = 1'b0, udr3 = 1'b0, tdi3 = 1'b0;
    logic                tdo3;

    int tests_run    = 0;
    int tests_failed = 0;

    jtag_uart_mc #(.DATA_W(DW), .DEPTH(DEP), .NCH(NCH)) dut (
        .clk_i(clk), .nreset_i(nreset), .wr_i(wr), .data_i(din), .rd_i(rd),
        .data_o(dout), .txmt_o(txmt), .txfl_o(txfl), .rxmt_o(rxmt), .rxfl_o(rxfl),
        .ir_i(ir), .uir_i(uir), .cdr_i(cdr), .sdr_i(sdr), .udr_i(udr),
        .tdi_i(tdi), .tdo_o(tdo)
    );

    jtag_uart_mc #(.DATA_W(DW), .DEPTH(4), .NCH(3)) dut3 (
        .clk_i(clk), .nreset_i(nreset), .wr_i(wr3), .data_i(din3), .rd_i(rd3),
        .data_o(dout3), .txmt_o(txmt3), .txfl_o(txfl3), .rxmt_o(rxmt3), .rxfl_o(rxfl3),
        .ir_i(ir3), .uir_i(uir3), .cdr_i(cdr3), .sdr_i(sdr3), .udr_i(udr3),
        .tdi_i(tdi3), .tdo_o(tdo3)
    );

    typedef struct {
        int         ch;
        logic       push;
        logic [7:0] word;
        logic [8:0] exp_sr;
        logic       exp_txmt;
    } tx_vec_t;

    tx_vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ir(input logic [1:0] op, input int ch);
        ir  = {CHW'(ch), op};
        uir = 1'b1;
        tick();
        uir = 1'b0;
    endtask

    task automatic capture();
        cdr = 1'b1;
        tick();
        cdr = 1'b0;
    endtask

    task automatic update();
        udr = 1'b1;
        tick();
        udr = 1'b0;
    endtask

    // tout collects tdo before each shift edge, so it holds the captured SR LSB-first
    task automatic shift9(input logic [8:0] tin, output logic [8:0] tout);
        for (int i = 0; i < 9; i++) begin
            tout[i] = tdo;
            tdi     = tin[i];
            sdr     = 1'b1;
            tick();
        end
        sdr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic user_push(input int ch, input logic [7:0] word);
        wr[ch]           = 1'b1;
        din[ch*DW +: DW] = word;
        tick();
        wr = '0;
    endtask

    task automatic rx_write(input logic [7:0] word);
        logic [8:0] unused_bits;
        shift9({word, 1'b0}, unused_bits);
        update();
    endtask

    task automatic tx_read(output logic [8:0] v);
        capture();
        shift9(9'h000, v);
    endtask

    task automatic applyStimulus(input tx_vec_t v, input int idx);
        logic [8:0] got;
        if (v.push) user_push(v.ch, v.word);
        set_ir(OP_TX, v.ch);
        tx_read(got);
        checkOutput($sformatf("tx_vec%0d_sr", idx), 32'(got), 32'(v.exp_sr));
        checkOutput($sformatf("tx_vec%0d_txmt", idx), 32'(txmt[v.ch]), 32'(v.exp_txmt));
    endtask

    initial begin
        logic [8:0] got;

        vecs[0] = '{ch: 1, push: 1'b1, word: 8'hA5, exp_sr: 9'h14B, exp_txmt: 1'b1};
        vecs[1] = '{ch: 0, push: 1'b1, word: 8'h3C, exp_sr: 9'h079, exp_txmt: 1'b1};
        vecs[2] = '{ch: 0, push: 1'b0, word: 8'h00, exp_sr: 9'h000, exp_txmt: 1'b1};
        vecs[3] = '{ch: 1, push: 1'b1, word: 8'hFF, exp_sr: 9'h1FF, exp_txmt: 1'b1};

        tick();
        tick();
        checkOutput("rst_txmt", 32'(txmt), 32'h3);
        checkOutput("rst_rxmt", 32'(rxmt), 32'h3);
        checkOutput("rst_txfl", 32'(txfl), 32'h0);
        checkOutput("rst_rxfl", 32'(rxfl), 32'h0);
        checkOutput("rst_dout", 32'(dout), 32'h0);
        checkOutput("rst_tdo", 32'(tdo), 32'h0);
        nreset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

        // Two queued words on channel 1 stream out in order
        user_push(1, 8'hA5);
        user_push(1, 8'h3C);
        checkOutput("seq_txmt1_before", 32'(txmt[1]), 32'h0);
        set_ir(OP_TX, 1);
        tx_read(got);
        checkOutput("seq_word0", 32'(got), 32'h14B);
        tx_read(got);
        checkOutput("seq_word1", 32'(got), 32'h079);
        checkOutput("seq_txmt1_after", 32'(txmt[1]), 32'h1);

        // Fill RX channel 0, overflow it, read STATUS twice, then drain
        set_ir(OP_RX, 0);
        for (int i = 0; i < 64; i++) rx_write(8'(i));
        checkOutput("rx_full_at_64", 32'(rxfl[0]), 32'h1);
        rx_write(8'hFF);
        checkOutput("rx_full_after_ovf", 32'(rxfl[0]), 32'h1);
        set_ir(OP_STATUS, 0);
        tx_read(got);
        checkOutput("status_ovf_set", 32'(got), 32'h019);
        tx_read(got);
        checkOutput("status_ovf_clr", 32'(got), 32'h009);
        for (int i = 0; i < 64; i++) begin
            rd[0] = 1'b1;
            tick();
            rd[0] = 1'b0;
            checkOutput($sformatf("rx_pop%0d", i), 32'(dout[DW-1:0]), 32'(i));
        end
        checkOutput("rx_empty_after_drain", 32'(rxmt[0]), 32'h1);
        rd[0] = 1'b1;
        tick();
        rd[0] = 1'b0;
        checkOutput("rx_pop_empty_hold", 32'(dout[DW-1:0]), 32'h3F);

        // Full TX FIFO: user push and JTAG pop on the same edge both land
        for (int i = 0; i < 64; i++) user_push(0, 8'(i));
        checkOutput("tx_full_at_64", 32'(txfl[0]), 32'h1);
        set_ir(OP_TX, 0);
        wr[0]      = 1'b1;
        din[DW-1:0] = 8'hEE;
        cdr        = 1'b1;
        tick();
        wr  = '0;
        cdr = 1'b0;
        checkOutput("tx_full_pushpop", 32'(txfl[0]), 32'h1);
        shift9(9'h000, got);
        checkOutput("tx_full_first", 32'(got), 32'h001);
        for (int i = 1; i < 64; i++) begin
            tx_read(got);
            checkOutput($sformatf("tx_drain%0d", i), 32'(got), 32'({8'(i), 1'b1}));
        end
        tx_read(got);
        checkOutput("tx_drain_last", 32'(got), 32'h1DD);
        checkOutput("tx_empty_after_drain", 32'(txmt[0]), 32'h1);

        // NCH=3 instance: channel 3 does not exist, so the TAP sits in BYPASS
        ir3  = {2'd3, 2'(OP_TX)};
        uir3 = 1'b1;
        tick();
        uir3 = 1'b0;
        checkOutput("byp3_initial", 32'(tdo3), 32'h0);
        sdr3 = 1'b1;
        tdi3 = 1'b1;
        tick();
        checkOutput("byp3_bit0", 32'(tdo3), 32'h1);
        tdi3 = 1'b0;
        tick();
        checkOutput("byp3_bit1", 32'(tdo3), 32'h0);
        tdi3 = 1'b1;
        tick();
        checkOutput("byp3_bit2", 32'(tdo3), 32'h1);
        sdr3 = 1'b0;
        tdi3 = 1'b0;

        // Reset halfway through an RX shift discards the partial word
        user_push(1, 8'h55);
        checkOutput("pre_rst_txmt1", 32'(txmt[1]), 32'h0);
        set_ir(OP_RX, 1);
        for (int i = 0; i < 4; i++) begin
            tdi = 1'b1;
            sdr = 1'b1;
            tick();
        end
        sdr    = 1'b0;
        tdi    = 1'b0;
        nreset = 1'b0;
        tick();
        checkOutput("mid_rst_txmt", 32'(txmt), 32'h3);
        checkOutput("mid_rst_rxmt", 32'(rxmt), 32'h3);
        checkOutput("mid_rst_txfl", 32'(txfl), 32'h0);
        checkOutput("mid_rst_rxfl", 32'(rxfl), 32'h0);
        checkOutput("mid_rst_dout", 32'(dout), 32'h0);
        checkOutput("mid_rst_tdo", 32'(tdo), 32'h0);
        nreset = 1'b1;
        tick();
        update();
        checkOutput("post_rst_no_push", 32'(rxmt), 32'h3);
        tdi = 1'b1;
        sdr = 1'b1;
        tick();
        sdr = 1'b0;
        tdi = 1'b0;
        checkOutput("post_rst_bypass", 32'(tdo), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
